// File: rtl/simple_bus_timer.sv
// simple_bus_timer: prescaled 32-bit down-counting timer on the simple register bus with level irq.
// Define TIMER_CAPTURE_EN to add the capture_in port, CAPTURE register and STATUS.CAPTURED.
module simple_bus_timer #(
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] wrAddr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] wrData,
  input  logic                          wr,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] rdAddr,
  input  logic                          rd,
  output logic [C_S_AXI_DATA_WIDTH-1:0] rdData,
  output logic                          irq
`ifdef TIMER_CAPTURE_EN
  ,
  input  logic                          capture_in
`endif
);
  localparam int AW = C_S_AXI_ADDR_WIDTH - 2;
  logic [AW-1:0] wa, ra;
  logic en, ar, ie, expired, tick, cnt_wr, sts_wr, expire, running, captured;
  logic [7:0] pre, psc;
  logic [31:0] load, count, count_nxt, cap;
  logic unused;
  assign unused = ^{rd, wrAddr[1:0], rdAddr[1:0]};
  assign wa = wrAddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign ra = rdAddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign tick = en && psc == pre;
  assign cnt_wr = wr && wa == AW'(2);
  assign sts_wr = wr && wa == AW'(3);
  assign expire = tick && count == 32'd1 && !cnt_wr;
  assign running = en && count != 32'd0;
  assign irq = expired && ie;
  always_comb count_nxt = cnt_wr ? wrData : (!tick || count == 32'd0) ? count :
                          count == 32'd1 ? (ar ? load : 32'd0) : count - 32'd1;
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      en <= 1'b0;
      ar <= 1'b0;
      ie <= 1'b0;
      pre <= 8'd0;
      psc <= 8'd0;
      load <= 32'd0;
      count <= 32'd0;
      expired <= 1'b0;
    end else begin
      if (wr && wa == AW'(0)) begin
        en <= wrData[0];
        ar <= wrData[1];
        ie <= wrData[2];
        pre <= wrData[15:8];
      end
      if (wr && wa == AW'(1)) load <= wrData;
      count <= count_nxt;
      psc <= (tick || !en) ? 8'd0 : psc + 8'd1;
      expired <= expire || (expired && !(sts_wr && wrData[0]));
    end
  end
`ifdef TIMER_CAPTURE_EN
  logic cap_prev;
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      cap_prev <= 1'b0;
      cap <= 32'd0;
      captured <= 1'b0;
    end else begin
      cap_prev <= capture_in;
      if (capture_in && !cap_prev) cap <= count;
      captured <= (capture_in && !cap_prev) || (captured && !(sts_wr && wrData[2]));
    end
  end
`else
  assign cap = 32'd0;
  assign captured = 1'b0;
`endif
  always_comb rdData = ra == AW'(0) ? {16'd0, pre, 5'd0, ie, ar, en} :
                       ra == AW'(1) ? load :
                       ra == AW'(2) ? count :
                       ra == AW'(3) ? {29'd0, captured, running, expired} :
                       ra == AW'(4) ? cap : 32'd0;
endmodule

// File: tb/tb_simple_bus_timer.sv
// tb_simple_bus_timer: directed stimulus, per-cycle check against a register-level model plus literal pins.
module tb_simple_bus_timer;
  logic clk = 0, rst = 1, wr = 0, rd = 0, cap_in = 0;
  logic [5:0] wa = 0, ra = 0;
  logic [31:0] wd = 0, rdata;
  logic irq;
  int tests = 0, fails = 0;
  bit go = 0;
  always #5 clk = ~clk;

  simple_bus_timer dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .wrAddr(wa), .wrData(wd), .wr(wr),
    .rdAddr(ra), .rd(rd), .rdData(rdata), .irq(irq)
`ifdef TIMER_CAPTURE_EN
    , .capture_in(cap_in)
`endif
  );

  bit m_en, m_ar, m_ie, m_exp, m_capd, m_cprev;
  logic [7:0] m_pre, m_psc;
  logic [31:0] m_load, m_count, m_cap;

  function automatic logic [31:0] m_read(logic [5:0] a);
    case (a[5:2])
      4'd0: return {16'd0, m_pre, 5'd0, m_ie, m_ar, m_en};
      4'd1: return m_load;
      4'd2: return m_count;
      4'd3: return {29'd0, m_capd, m_en && m_count != 0, m_exp};
`ifdef TIMER_CAPTURE_EN
      4'd4: return m_cap;
`endif
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    bit t, cw, sw, rise;
    logic [31:0] nc;
    forever begin
      @(negedge clk);
      if (go) begin
        tests++;
        if (rdata !== m_read(ra)) begin
          fails++;
          $display("FAIL model rdData@%h: got %h expected %h", ra, rdata, m_read(ra));
        end
        tests++;
        if (irq !== (m_exp && m_ie)) begin
          fails++;
          $display("FAIL model irq: got %b expected %b", irq, m_exp && m_ie);
        end
      end
      if (rst) begin
        {m_en, m_ar, m_ie, m_exp, m_capd, m_cprev} = '0;
        m_pre = 0; m_psc = 0; m_load = 0; m_count = 0; m_cap = 0;
      end else begin
        t = m_en && m_psc == m_pre;
        cw = wr && wa[5:2] == 4'd2;
        sw = wr && wa[5:2] == 4'd3;
        rise = cap_in && !m_cprev;
        nc = cw ? wd : (t && m_count != 0) ? (m_count == 1 ? (m_ar ? m_load : 0) : m_count - 1) : m_count;
`ifdef TIMER_CAPTURE_EN
        if (rise) m_cap = m_count;
        m_capd = rise || (m_capd && !(sw && wd[2]));
`endif
        m_cprev = cap_in;
        m_exp = (t && m_count == 1 && !cw) || (m_exp && !(sw && wd[0]));
        m_psc = (!m_en || t) ? 8'd0 : m_psc + 8'd1;
        m_count = nc;
        if (wr && wa[5:2] == 4'd0) begin
          m_en = wd[0]; m_ar = wd[1]; m_ie = wd[2]; m_pre = wd[15:8];
        end
        if (wr && wa[5:2] == 4'd1) m_load = wd;
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic rdchk(input string n, input logic [5:0] a, input logic [31:0] exp);
    ra = a; rd = 1; #1;
    chk(n, rdata, exp);
    rd = 0;
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wreg(input logic [5:0] a, input logic [31:0] d, input int n);
    wa = a; wd = d; wr = 1;
    cyc(n);
    wr = 0;
  endtask

  initial begin
    cyc(2);
    rst = 0; go = 1;
    for (int a = 0; a <= 'h14; a += 4) rdchk("reset read", 6'(a), 0);
    chk("reset irq", {31'd0, irq}, 0);
    wreg(6'h04, 3, 1);
    wreg(6'h08, 3, 1);
    wreg(6'h00, 32'h5, 1);
    rdchk("oneshot c3", 6'h08, 3);
    cyc(1); rdchk("oneshot c2", 6'h08, 2);
    cyc(1); rdchk("oneshot c1", 6'h08, 1);
    chk("oneshot irq low", {31'd0, irq}, 0);
    cyc(1); rdchk("oneshot c0", 6'h08, 0);
    rdchk("oneshot status", 6'h0C, 1);
    chk("oneshot irq", {31'd0, irq}, 1);
    cyc(3); rdchk("oneshot idle", 6'h08, 0);
    wreg(6'h0C, 1, 1);
    chk("w1c irq", {31'd0, irq}, 0);
    wreg(6'h00, 0, 1);
    wreg(6'h04, 2, 1);
    wreg(6'h08, 2, 1);
    wreg(6'h00, 32'h207, 1);
    rdchk("reload c2", 6'h08, 2);
    cyc(3); rdchk("reload c1", 6'h08, 1);
    cyc(3); rdchk("reload back", 6'h08, 2);
    rdchk("reload status", 6'h0C, 3);
    chk("reload irq", {31'd0, irq}, 1);
    wreg(6'h0C, 1, 1);
    rdchk("clear status", 6'h0C, 2);
    cyc(1);
    wreg(6'h0C, 1, 4);
    rdchk("set beats w1c", 6'h0C, 3);
    rdchk("set beats w1c cnt", 6'h08, 2);
    wreg(6'h0C, 1, 1);
    rdchk("late w1c", 6'h0C, 2);
    chk("late w1c irq", {31'd0, irq}, 0);
    wreg(6'h00, 0, 1);
    wreg(6'h00, 32'h5, 1);
    wreg(6'h08, 32'h100, 1);
    rdchk("write beats tick", 6'h08, 32'h100);
    cyc(1); rdchk("after write tick", 6'h08, 32'hFF);
    wreg(6'h08, 50, 1);
    cap_in = 1;
    cyc(1);
    cap_in = 0;
    rdchk("cap count", 6'h08, 49);
`ifdef TIMER_CAPTURE_EN
    rdchk("capture", 6'h10, 50);
    rdchk("cap status", 6'h0C, 6);
    cyc(2); rdchk("capture hold", 6'h10, 50);
`else
    rdchk("no capture", 6'h10, 0);
    rdchk("no cap status", 6'h0C, 2);
`endif
    rst = 1; wa = 6'h08; wd = 7; wr = 1;
    cyc(1);
    wr = 0; rst = 0;
    rdchk("rst count", 6'h08, 0);
    rdchk("rst ctrl", 6'h00, 0);
    rdchk("rst status", 6'h0C, 0);
    cyc(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
